// File: rtl/one_hot_encoder_pipe_if.sv
// Valid/ready bus for the one-hot to binary encoder stage.
// The master modport is the upstream/downstream side; the slave modport is the encoder.
interface one_hot_encoder_pipe_if #(
  parameter int N     = 8,
  parameter int W     = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_onehot;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_code;
  logic             out_err_zero;
  logic             out_err_multi;
  logic [CNT_W-1:0] err_count;
  logic             clr_err;

  modport master (
    output in_valid, in_onehot, out_ready, clr_err,
    input  in_ready, out_valid, out_code, out_err_zero, out_err_multi, err_count
  );

  modport slave (
    input  in_valid, in_onehot, out_ready, clr_err,
    output in_ready, out_valid, out_code, out_err_zero, out_err_multi, err_count
  );
endinterface

// File: rtl/one_hot_encoder_pipe.sv
// One-hot to binary encoder behind a single registered valid/ready stage.
// Zero-hot and multi-hot words are flagged and counted in a saturating counter.
module one_hot_encoder_pipe #(
  parameter int N     = 8,
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  one_hot_encoder_pipe_if.slave bus
);

  logic [N-1:0]     word;
  logic [W-1:0]     enc_code;
  logic             enc_zero;
  logic             enc_multi;
  logic             in_fire;
  logic             out_fire;
  logic             out_valid_reg;
  logic [W-1:0]     out_code_reg;
  logic             err_zero_reg;
  logic             err_multi_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] err_count_next;

  assign word = bus.in_onehot;

  // Scan from the top down so the lowest set bit is the last writer (LSB priority).
  always_comb begin
    enc_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (word[i]) begin
        enc_code = W'(i);
      end
    end
  end

  assign enc_zero  = (word == '0);
  assign enc_multi = |(word & (word - N'(1)));

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_reg && bus.out_ready;

  // Clear is applied before counting, so clear plus an erroneous transfer yields 1.
  always_comb begin
    cnt_base       = bus.clr_err ? '0 : err_count_reg;
    err_count_next = cnt_base;
    if (in_fire && (enc_zero || enc_multi) && (cnt_base != '1)) begin
      err_count_next = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_code_reg  <= '0;
      err_zero_reg  <= 1'b0;
      err_multi_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_count_reg <= err_count_next;
      if (in_fire) begin
        out_valid_reg <= 1'b1;
        out_code_reg  <= enc_code;
        err_zero_reg  <= enc_zero;
        err_multi_reg <= enc_multi;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.out_code      = out_code_reg;
  assign bus.out_err_zero  = err_zero_reg;
  assign bus.out_err_multi = err_multi_reg;
  assign bus.err_count     = err_count_reg;

endmodule

// File: tb/tb_one_hot_encoder_pipe.sv
// Directed self-checking bench for one_hot_encoder_pipe: streaming, error flags,
// backpressure, counter saturation/clear and asynchronous reset.
module tb_one_hot_encoder_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  one_hot_encoder_pipe_if #(.N(8), .W(3), .CNT_W(8)) bus ();

  one_hot_encoder_pipe #(.N(8), .W(3), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_onehot = 8'h00;
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_code !== 3'd0 || bus.out_err_zero !== 1'b0 || bus.out_err_multi !== 1'b0) begin
      errors++; $display("FAIL reset_fields: got code=%0d z=%b m=%b want 0 0 0",
                         bus.out_code, bus.out_err_zero, bus.out_err_multi);
    end
    checks++;
    if (bus.err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err_count: got %0d want 0", bus.err_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    $display("reset: out_valid=%b err_count=%0d", bus.out_valid, bus.err_count);
  endtask

  task automatic test_stream();
    logic [7:0] w;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w             = 8'h01 << i;
      bus.in_valid  = 1'b1;
      bus.in_onehot = w;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 3'(i) ||
          bus.out_err_zero !== 1'b0 || bus.out_err_multi !== 1'b0 || bus.err_count !== 8'd0) begin
        errors++; $display("FAIL stream[%0d]: got v=%b code=%0d z=%b m=%b cnt=%0d want 1 %0d 0 0 0",
                           i, bus.out_valid, bus.out_code, bus.out_err_zero,
                           bus.out_err_multi, bus.err_count, i);
      end
      $display("stream: in=%h code=%0d", w, bus.out_code);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_errors();
    logic [7:0] vec  [4] = '{8'h00, 8'b0010_1000, 8'b1100_0000, 8'hFF};
    logic [2:0] code [4] = '{3'd0, 3'd3, 3'd6, 3'd0};
    logic       zero [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_onehot = vec[i];
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== code[i] ||
          bus.out_err_zero !== zero[i] || bus.out_err_multi !== !zero[i]) begin
        errors++; $display("FAIL err_word[%0d]: got v=%b code=%0d z=%b m=%b want 1 %0d %b %b",
                           i, bus.out_valid, bus.out_code, bus.out_err_zero,
                           bus.out_err_multi, code[i], zero[i], !zero[i]);
      end
      checks++;
      if (bus.err_count !== 8'(i + 1)) begin
        errors++; $display("FAIL err_count[%0d]: got %0d want %0d", i, bus.err_count, i + 1);
      end
      $display("error word: in=%h code=%0d z=%b m=%b cnt=%0d", vec[i], bus.out_code,
               bus.out_err_zero, bus.out_err_multi, bus.err_count);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    // err_count is 4 on entry
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_onehot = 8'h10;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd4 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_first: got v=%b code=%0d in_ready=%b want 1 4 0",
                         bus.out_valid, bus.out_code, bus.in_ready);
    end
    bus.in_onehot = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd4 || bus.out_err_zero !== 1'b0 ||
          bus.in_ready !== 1'b0 || bus.err_count !== 8'd4) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b code=%0d z=%b in_ready=%b cnt=%0d want 1 4 0 0 4",
                           c, bus.out_valid, bus.out_code, bus.out_err_zero, bus.in_ready, bus.err_count);
      end
      $display("stall: code=%0d in_ready=%b", bus.out_code, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd0 || bus.out_err_zero !== 1'b1 ||
        bus.err_count !== 8'd5) begin
      errors++; $display("FAIL bp_second: got v=%b code=%0d z=%b cnt=%0d want 1 0 1 5",
                         bus.out_valid, bus.out_code, bus.out_err_zero, bus.err_count);
    end
    $display("released: code=%0d z=%b cnt=%0d", bus.out_code, bus.out_err_zero, bus.err_count);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    // err_count is 5 on entry
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_onehot = 8'h00;
    repeat (249) tick();
    checks++;
    if (bus.err_count !== 8'd254) begin
      errors++; $display("FAIL sat_254: got %0d want 254", bus.err_count);
    end
    repeat (51) tick();
    checks++;
    if (bus.err_count !== 8'd255) begin
      errors++; $display("FAIL sat_255: got %0d want 255", bus.err_count);
    end
    $display("saturation: 300 zero words cnt=%0d", bus.err_count);
    bus.clr_err = 1'b1;
    tick();
    checks++;
    if (bus.err_count !== 8'd1) begin
      errors++; $display("FAIL clr_with_err: got %0d want 1", bus.err_count);
    end
    bus.in_onehot = 8'h04;
    tick();
    checks++;
    if (bus.err_count !== 8'd0 || bus.out_code !== 3'd2) begin
      errors++; $display("FAIL clr_with_good: got cnt=%0d code=%0d want 0 2", bus.err_count, bus.out_code);
    end
    bus.clr_err   = 1'b0;
    bus.in_onehot = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.err_count !== 8'd1) begin
      errors++; $display("FAIL count_after_clr: got %0d want 1", bus.err_count);
    end
    $display("clear: cnt=%0d", bus.err_count);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_onehot = 8'h00;
    tick();
    bus.in_onehot = 8'h02;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd1 || bus.err_count !== 8'd2) begin
      errors++; $display("FAIL mid_pre: got v=%b code=%0d cnt=%0d want 1 1 2",
                         bus.out_valid, bus.out_code, bus.err_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_count !== 8'd0 || bus.out_code !== 3'd0) begin
      errors++; $display("FAIL mid_async: got v=%b cnt=%0d code=%0d want 0 0 0",
                         bus.out_valid, bus.err_count, bus.out_code);
    end
    $display("async reset: out_valid=%b cnt=%0d", bus.out_valid, bus.err_count);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_onehot = 8'h20;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd5 || bus.err_count !== 8'd0) begin
      errors++; $display("FAIL mid_after: got v=%b code=%0d cnt=%0d want 1 5 0",
                         bus.out_valid, bus.out_code, bus.err_count);
    end
    $display("after reset: in=20 code=%0d", bus.out_code);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_replay: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_errors();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
